// File: rtl/rv_decode_pkg.sv
// rv_decode_pkg: RV32 encoding constants shared by the decode stage and
// alu_control, plus the immediate-format enum and the supported-op check.
package rv_decode_pkg;

  // Major opcodes
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_L    = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  // R-type func3 / func7
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  // Branch func3 (this core's encoding: bge sits on 010)
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b010;

  typedef enum logic [2:0] {
    IMM_NONE,  // R-type or unknown opcode: imm = 0
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_J
  } imm_type_e;

  // Opcode is known; R and B additionally need a supported func combo.
  function automatic logic op_supported(input logic [6:0] op,
                                        input logic [2:0] f3,
                                        input logic [6:0] f7);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_R: ok = ({f7, f3} == {F7_BASE, F3_AND}) ||
                 ({f7, f3} == {F7_BASE, F3_OR})  ||
                 ({f7, f3} == {F7_BASE, F3_ADD}) ||
                 ({f7, f3} == {F7_SUB,  F3_ADD});
      OP_B: ok = (f3 == F3_BEQ) || (f3 == F3_BLT) || (f3 == F3_BGE);
      OP_I, OP_L, OP_S, OP_JAL, OP_JALR: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/id_decode_stage_if.sv
// id_decode_stage_if: fetch-side and downstream-side handshakes of the
// decode stage.
//   slave  : the decode stage (consumes in_*, flush, out_ready)
//   master : the environment (fetch + downstream consumer)
interface id_decode_stage_if #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
);
  // fetch side
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            flush;
  // downstream side
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [6:0]      opcode;
  logic [2:0]      func3;
  logic [6:0]      func7;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [XLEN-1:0] imm;
  logic            illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, opcode, func3, func7,
           rd, rs1, rs2, imm, illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, opcode, func3, func7,
           rd, rs1, rs2, imm, illegal
  );
endinterface

// File: rtl/id_decode_stage_imm_gen.sv
// imm_gen: combinational immediate generator.
//   instr    in  32    raw instruction
//   imm      out XLEN  sign-extended immediate (0 for R-type / unknown)
//   imm_type out enum  immediate format selected by the opcode
// Knows nothing about func legality; callers zero imm for illegal combos.
module imm_gen
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_type_e       imm_type
);

  // func3 field carries no immediate bits
  logic unused_f3;
  assign unused_f3 = ^instr[14:12];

  always_comb begin
    imm_type = IMM_NONE;
    case (instr[6:0])
      OP_I, OP_L, OP_JALR: imm_type = IMM_I;
      OP_S:                imm_type = IMM_S;
      OP_B:                imm_type = IMM_B;
      OP_JAL:              imm_type = IMM_J;
      default:             imm_type = IMM_NONE;
    endcase
  end

  always_comb begin
    imm = '0;
    case (imm_type)
      IMM_I: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      IMM_S: imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
      IMM_J: imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12],
                    instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/id_decode_stage.sv
// id_decode_stage: decode between fetch and alu_control.
//   clk    in  clock
//   rst_n  in  synchronous active-low reset
//   bus    slave modport of id_decode_stage_if
//            fetch side : in_valid/in_ready, in_instr, in_pc, flush
//            downstream : out_valid/out_ready, out_pc, opcode, func3, func7,
//                         rd, rs1, rs2, imm, illegal
// Decoded entries live in a main register feeding the outputs and a one-entry
// skid register that absorbs the accept made while downstream stalls, so
// in_ready depends only on registered state.
module id_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input logic             clk,
  input logic             rst_n,
  id_decode_stage_if.slave bus
);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } dec_t;

  dec_t            dec_in;
  dec_t            main_q, skid_q;
  logic            main_v, skid_v;
  logic [XLEN-1:0] gen_imm;
  imm_type_e       gen_type;
  logic            legal;
  logic            accept, pop;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr    (bus.in_instr),
    .imm      (gen_imm),
    .imm_type (gen_type)
  );

  // Fields pass through raw even when illegal; only imm is suppressed.
  always_comb begin
    dec_in         = '0;
    legal          = op_supported(bus.in_instr[6:0], bus.in_instr[14:12],
                                  bus.in_instr[31:25]);
    dec_in.pc      = bus.in_pc;
    dec_in.opcode  = bus.in_instr[6:0];
    dec_in.func3   = bus.in_instr[14:12];
    dec_in.func7   = bus.in_instr[31:25];
    dec_in.rd      = bus.in_instr[11:7];
    dec_in.rs1     = bus.in_instr[19:15];
    dec_in.rs2     = bus.in_instr[24:20];
    dec_in.imm     = (legal && (gen_type != IMM_NONE)) ? gen_imm : '0;
    dec_in.illegal = ~legal;
  end

  assign bus.in_ready = rst_n & ~skid_v;
  assign accept       = bus.in_valid & bus.in_ready;
  assign pop          = main_v & bus.out_ready;

  // Skid is only ever full while main is full, and in_ready=0 then, so
  // "pop with skid full" and "accept" never coincide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else if (bus.flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (pop) begin
      if (skid_v) begin
        main_q <= skid_q;
        skid_v <= 1'b0;
      end else if (accept) begin
        main_q <= dec_in;
      end else begin
        main_v <= 1'b0;
      end
    end else if (accept) begin
      if (!main_v) begin
        main_q <= dec_in;
        main_v <= 1'b1;
      end else begin
        skid_q <= dec_in;
        skid_v <= 1'b1;
      end
    end
  end

  assign bus.out_valid = main_v;
  assign bus.out_pc    = main_q.pc;
  assign bus.opcode    = main_q.opcode;
  assign bus.func3     = main_q.func3;
  assign bus.func7     = main_q.func7;
  assign bus.rd        = main_q.rd;
  assign bus.rs1       = main_q.rs1;
  assign bus.rs2       = main_q.rs2;
  assign bus.imm       = main_q.imm;
  assign bus.illegal   = main_q.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed bench for id_decode_stage. Inputs change 1ns after the rising
// edge; outputs are sampled on the falling edge.
module tb_id_decode_stage;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  id_decode_stage_if #(.XLEN(32), .PC_W(32)) bus ();

  id_decode_stage #(.XLEN(32), .PC_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {opcode, func3, func7, rd, rs1, rs2}
  function automatic logic [31:0] flds();
    return {bus.opcode, bus.func3, bus.func7, bus.rd, bus.rs1, bus.rs2};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr,
                       input logic [31:0] pc);
    bus.in_valid = v;
    bus.in_instr = instr;
    bus.in_pc    = pc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h00500093, 32'h10);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++;
      $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    step();
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.out_pc, flds(), bus.imm, bus.illegal} !== '0) begin errors++;
      $display("FAIL reset_outputs: valid=%b pc=%h flds=%h imm=%h ill=%b want all 0",
               bus.out_valid, bus.out_pc, flds(), bus.imm, bus.illegal); end
    step();
    drive(1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++;
      $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_addi();
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h00500093, 32'h100);
    step();
    drive(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h100) begin errors++;
      $display("FAIL addi_valid: valid=%b pc=%h want 1 00000100", bus.out_valid, bus.out_pc); end
    checks++;
    if (flds() !== {7'b0010011, 3'b000, 7'b0, 5'd1, 5'd0, 5'd5}) begin errors++;
      $display("FAIL addi_fields: got %h want %h", flds(),
               {7'b0010011, 3'b000, 7'b0, 5'd1, 5'd0, 5'd5}); end
    checks++;
    if (bus.imm !== 32'd5 || bus.illegal !== 1'b0) begin errors++;
      $display("FAIL addi_imm: imm=%h ill=%b want 00000005 0", bus.imm, bus.illegal); end
    step();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++;
      $display("FAIL addi_drain: out_valid got %b want 0", bus.out_valid); end
  endtask

  // back-to-back beq, sw, blt, jal, jalr, lw at one per cycle
  task automatic test_back_to_back();
    logic [31:0] ins [6];
    logic [31:0] ef  [6];
    logic [31:0] ei  [6];
    ins[0] = 32'hFE000EE3; ef[0] = {7'b1100011, 3'b000, 7'b1111111, 5'd29, 5'd0, 5'd0}; ei[0] = 32'hFFFFFFFC;
    ins[1] = 32'h0020A423; ef[1] = {7'b0100011, 3'b010, 7'b0, 5'd8, 5'd1, 5'd2};        ei[1] = 32'd8;
    ins[2] = 32'h0020C463; ef[2] = {7'b1100011, 3'b100, 7'b0, 5'd8, 5'd1, 5'd2};        ei[2] = 32'd8;
    ins[3] = 32'h008000EF; ef[3] = {7'b1101111, 3'b000, 7'b0, 5'd1, 5'd0, 5'd8};        ei[3] = 32'd8;
    ins[4] = 32'h00008067; ef[4] = {7'b1100111, 3'b000, 7'b0, 5'd0, 5'd1, 5'd0};        ei[4] = 32'd0;
    ins[5] = 32'h0040A403; ef[5] = {7'b0000011, 3'b010, 7'b0, 5'd8, 5'd1, 5'd4};        ei[5] = 32'd4;
    bus.out_ready = 1'b1;
    drive(1'b1, ins[0], 32'h200);
    for (int i = 0; i < 6; i++) begin
      step();
      if (i < 5) drive(1'b1, ins[i+1], 32'h204 + 32'(4*i));
      else       drive(1'b0, 32'h0, 32'h0);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h200 + 32'(4*i) ||
          bus.in_ready !== 1'b1) begin errors++;
        $display("FAIL b2b_hs[%0d]: valid=%b pc=%h rdy=%b want 1 %h 1", i,
                 bus.out_valid, bus.out_pc, bus.in_ready, 32'h200 + 32'(4*i)); end
      checks++;
      if (flds() !== ef[i] || bus.imm !== ei[i] || bus.illegal !== 1'b0) begin errors++;
        $display("FAIL b2b_dec[%0d]: flds=%h imm=%h ill=%b want %h %h 0", i,
                 flds(), bus.imm, bus.illegal, ef[i], ei[i]); end
    end
    step();
  endtask

  task automatic test_illegal();
    logic [31:0] ins [3];
    logic [31:0] ef  [3];
    ins[0] = 32'h0000007F; ef[0] = {7'b1111111, 3'b000, 7'b0, 5'd0, 5'd0, 5'd0};
    ins[1] = 32'h022081B3; ef[1] = {7'b0110011, 3'b000, 7'b0000001, 5'd3, 5'd1, 5'd2};
    ins[2] = 32'hFE001EE3; ef[2] = {7'b1100011, 3'b001, 7'b1111111, 5'd29, 5'd0, 5'd0};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ins[i], 32'h300 + 32'(4*i));
      step();
      drive(1'b0, 32'h0, 32'h0);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.illegal !== 1'b1 || bus.imm !== 32'h0) begin errors++;
        $display("FAIL illegal[%0d]: valid=%b ill=%b imm=%h want 1 1 00000000", i,
                 bus.out_valid, bus.illegal, bus.imm); end
      checks++;
      if (flds() !== ef[i]) begin errors++;
        $display("FAIL illegal_raw[%0d]: got %h want %h", i, flds(), ef[i]); end
    end
    step();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 32'h400);   // add
    step();
    drive(1'b1, 32'h40208233, 32'h404);   // sub
    step();
    drive(1'b1, 32'h0020E2B3, 32'h408);   // or
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_pc !== 32'h400) begin errors++;
      $display("FAIL bp_full: rdy=%b pc=%h want 0 00000400", bus.in_ready, bus.out_pc); end
    step();
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_pc !== 32'h400 ||
        flds() !== {7'b0110011, 3'b000, 7'b0, 5'd3, 5'd1, 5'd2}) begin errors++;
      $display("FAIL bp_hold: rdy=%b valid=%b pc=%h flds=%h", bus.in_ready,
               bus.out_valid, bus.out_pc, flds()); end
    bus.out_ready = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (bus.out_pc !== 32'h404 || bus.func7 !== 7'b0100000 || bus.rd !== 5'd4 ||
        bus.in_ready !== 1'b1) begin errors++;
      $display("FAIL bp_second: pc=%h f7=%b rd=%0d rdy=%b want 00000404 0100000 4 1",
               bus.out_pc, bus.func7, bus.rd, bus.in_ready); end
    step();
    drive(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h408 || bus.func3 !== 3'b110 ||
        bus.rd !== 5'd5) begin errors++;
      $display("FAIL bp_third: valid=%b pc=%h f3=%b rd=%0d want 1 00000408 110 5",
               bus.out_valid, bus.out_pc, bus.func3, bus.rd); end
    step();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++;
      $display("FAIL bp_nodup: out_valid got %b want 0", bus.out_valid); end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h0020F333, 32'h500);   // and
    step();
    drive(1'b1, 32'h0040A403, 32'h504);   // lw
    step();
    drive(1'b1, 32'h008000EF, 32'h508);   // jal, dropped
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++;
      $display("FAIL flush_full: valid=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++;
        $display("FAIL flush_ghost[%0d]: out_valid=%b pc=%h want 0", i, bus.out_valid, bus.out_pc); end
    end
    // accept coinciding with flush on an empty stage is dropped too
    drive(1'b1, 32'hFFF00393, 32'h50C);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    drive(1'b1, 32'h00008067, 32'h510);   // jalr
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++;
      $display("FAIL flush_accept: out_valid=%b want 0", bus.out_valid); end
    step();
    drive(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h510 || bus.opcode !== 7'b1100111) begin errors++;
      $display("FAIL flush_resume: valid=%b pc=%h op=%b want 1 00000510 1100111",
               bus.out_valid, bus.out_pc, bus.opcode); end
    step();
  endtask

  task automatic test_reset_mid_stream();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h0040A403, 32'h600);
    step();
    drive(1'b1, 32'h008000EF, 32'h604);
    step();
    drive(1'b1, 32'h0020E2B3, 32'h608);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++;
      $display("FAIL rst_mid_rdy: got %b want 0", bus.in_ready); end
    step();
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.out_pc, flds(), bus.imm, bus.illegal, bus.in_ready} !== '0) begin errors++;
      $display("FAIL rst_mid_zero: valid=%b pc=%h flds=%h imm=%h rdy=%b want all 0",
               bus.out_valid, bus.out_pc, flds(), bus.imm, bus.in_ready); end
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 32'hFFF00393, 32'h60C);   // addi x7,x0,-1
    step();
    drive(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h60C || bus.imm !== 32'hFFFFFFFF ||
        flds() !== {7'b0010011, 3'b000, 7'b1111111, 5'd7, 5'd0, 5'd31}) begin errors++;
      $display("FAIL rst_resume: valid=%b pc=%h imm=%h flds=%h", bus.out_valid,
               bus.out_pc, bus.imm, flds()); end
    step();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++;
      $display("FAIL rst_nolost: out_valid=%b pc=%h want 0", bus.out_valid, bus.out_pc); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_addi();
    test_back_to_back();
    test_illegal();
    test_backpressure();
    test_flush();
    test_reset_mid_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
